alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Sequencing front end that drives the 8-bit ALU.
- Accepts one operation per valid/ready request from the decoder.
- Owns the accumulator (A) and flag (F) registers and drives the ALU a/b/opcode inputs from registers.
- Captures the ALU result and builds the full Z80 S/Z/H/PV/N/C flag byte; the ALU itself supplies only the result.
- Returns the result and flags over a valid/ready response channel.

Parameters:
ACC_RST, 8'hFF, accumulator reset value
FLG_RST, 8'hFF, flag register reset value

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_op  in  5  ALU opcode (alu_pkg encoding); 5'h0E is compare (CP)
req_src  in  8  source operand (ALU b)
resp_valid  out  1  response present
resp_ready  in  1  consumer accepts the response
resp_result  out  8  operation result (CP: the subtraction result)
resp_flags  out  8  new flag byte
resp_err  out  1  request op was illegal
acc  out  8  accumulator register
flags  out  8  flag register: 7 S, 6 Z, 5 X, 4 H, 3 X, 2 PV, 1 N, 0 C
alu_a  out  8  registered ALU operand a
alu_b  out  8  registered ALU operand b
alu_opcode  out  5  registered ALU opcode
alu_out  in  8  ALU result
alu_status  in  8  ALU status; ignored, flags are built locally

Behaviour:
- Reset (async assert, sync release): state IDLE, acc=ACC_RST, flags=FLG_RST.
- All other outputs reset to 0, except req_ready, which is 1 because it is decoded from IDLE.
- Reset asserted mid-operation abandons the operation: no writeback and no response.

FSM states are IDLE, EXEC and RESP.
- IDLE: req_ready=1.
  - When req_valid is high, the request is accepted at the edge.
  - alu_a is loaded from acc, alu_b from req_src, and alu_opcode from the mapped op.
  - The op and an error bit are latched, then the FSM goes to EXEC.
- EXEC (one cycle): the ALU settles combinationally.
  - At the edge, alu_out is captured into resp_result and the flags are computed into resp_flags.
  - Writeback: acc is updated unless the op is CP or illegal; flags are updated unless the op is illegal.
  - resp_valid is set to 1 and the FSM goes to RESP.
- RESP: resp_* are held stable while resp_valid=1.
  - When resp_ready is high at an edge, resp_valid clears and the FSM goes to IDLE.
  - req_ready stays 0 throughout EXEC and RESP.
- Latency: with resp_ready tied high, resp_valid is seen 2 cycles after acceptance and the next request is accepted 3 cycles after the previous one.

Op mapping:
- CP (0x0E) is driven to the ALU as SUB.
- Shift and rotate ops (0x06..0x0B) force alu_b=1, giving a single-bit shift.
- INC and DEC operate on acc; req_src is ignored and alu_b=0.
- ALU COMPARE (0x05) and codes 0x0F..0x1F are illegal:
  - alu_opcode is driven as 0;
  - resp_err=1, resp_result=0 and resp_flags equals the current flags;
  - acc and flags are unchanged.

Flags are built from the registered alu_a/alu_b and the captured result r:
- Common to all legal ops: S=r[7], Z=(r==0), X bits=0.
- ADD: C = carry out of bit 7; H = carry out of bit 3; PV = signed overflow; N=0.
- SUB and CP: C = borrow (b>a unsigned); H = borrow from bit 4; PV = signed overflow; N=1.
- AND: H=1, C=0, N=0, PV = even parity of r.
- OR and XOR: H=0, C=0, N=0, PV = even parity of r.
- SLL, SLA, ROL: C=a[7].
- SRL, SRA, ROR: C=a[0].
- All shifts and rotates: H=0, N=0, PV=parity.
- INC: C is preserved; H=(a[3:0]==4'hF); PV=(a==8'h7F); N=0.
- DEC: C is preserved; H=(a[3:0]==0); PV=(a==8'h80); N=1.

Decomposition:
- alu_pkg holds:
  - the opcode localparams (ADD=0 .. DEC=13, CP=14);
  - the flag bit index constants (FLG_S=7, FLG_Z=6, FLG_H=4, FLG_PV=2, FLG_N=1, FLG_C=0);
  - the FSM state enum typedef.
- One combinational sub-module, alu_flag_gen:
  - inputs: op, a, b, r, old C;
  - output: the flag byte;
  - contains the 9-bit and 5-bit add/sub chains and the parity tree.

Test Plan:
1. acc=7F, ADD src=01 → resp_result=80, flags=94, acc=80; resp_valid 2 cycles after acceptance.
2. acc=00, SUB src=01 → result FF, flags=93, acc=FF.
3. acc=42, CP src=42 → resp_result=00, flags=42, acc stays 42.
4. acc=81, SRL → alu_b=01, result 40, flags=01.
5. acc=F0, AND src=0F → result 00, flags=54. Then acc=FF with C=1, INC → acc=00, flags=51.
6. Control cases:
   - resp_ready held low for 5 cycles → resp_* stable and req_ready=0.
   - req_op=05 → resp_err=1, acc and flags unchanged.
   - rst_n pulsed low during EXEC → acc=FF, flags=FF, resp_valid=0, alu_* outputs=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode, flag-index and FSM-state definitions shared by the ALU issue controller
package alu_pkg;

  localparam logic [4:0] OP_ADD     = 5'd0;
  localparam logic [4:0] OP_SUB     = 5'd1;
  localparam logic [4:0] OP_AND     = 5'd2;
  localparam logic [4:0] OP_OR      = 5'd3;
  localparam logic [4:0] OP_XOR     = 5'd4;
  localparam logic [4:0] OP_COMPARE = 5'd5;
  localparam logic [4:0] OP_SLL     = 5'd6;
  localparam logic [4:0] OP_SRL     = 5'd7;
  localparam logic [4:0] OP_SLA     = 5'd8;
  localparam logic [4:0] OP_SRA     = 5'd9;
  localparam logic [4:0] OP_ROL     = 5'd10;
  localparam logic [4:0] OP_ROR     = 5'd11;
  localparam logic [4:0] OP_INC     = 5'd12;
  localparam logic [4:0] OP_DEC     = 5'd13;
  localparam logic [4:0] OP_CP      = 5'd14;

  localparam int FLG_S  = 7;
  localparam int FLG_Z  = 6;
  localparam int FLG_H  = 4;
  localparam int FLG_PV = 2;
  localparam int FLG_N  = 1;
  localparam int FLG_C  = 0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_RESP
  } state_e;

  // The raw ALU compare and everything above CP have no Z80 meaning here.
  function automatic logic op_illegal(input logic [4:0] op);
    return (op == OP_COMPARE) || (op > OP_CP);
  endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// rtl/alu_flag_gen.sv - builds the Z80 S/Z/H/PV/N/C flag byte from operands and ALU result
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [4:0] op_i,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic [7:0] r_i,
  input  logic       c_i,
  output logic [7:0] flags_o
);

  logic c_add;
  logic c_sub;
  logic h_add;
  logic h_sub;
  logic par;

  // Carry/borrow chains: a result above the operand range means bit 8 (or 4) was set.
  assign c_add = ({1'b0, a_i} + {1'b0, b_i}) > 9'h0FF;
  assign c_sub = ({1'b0, a_i} - {1'b0, b_i}) > 9'h0FF;
  assign h_add = ({1'b0, a_i[3:0]} + {1'b0, b_i[3:0]}) > 5'h0F;
  assign h_sub = ({1'b0, a_i[3:0]} - {1'b0, b_i[3:0]}) > 5'h0F;
  assign par   = ~^r_i;

  always_comb begin
    flags_o        = 8'h00;
    flags_o[FLG_S] = r_i[7];
    flags_o[FLG_Z] = (r_i == 8'h00);
    case (op_i)
      OP_ADD: begin
        flags_o[FLG_C]  = c_add;
        flags_o[FLG_H]  = h_add;
        flags_o[FLG_PV] = (a_i[7] == b_i[7]) && (r_i[7] != a_i[7]);
      end
      OP_SUB, OP_CP: begin
        flags_o[FLG_C]  = c_sub;
        flags_o[FLG_H]  = h_sub;
        flags_o[FLG_PV] = (a_i[7] != b_i[7]) && (r_i[7] != a_i[7]);
        flags_o[FLG_N]  = 1'b1;
      end
      OP_AND: begin
        flags_o[FLG_H]  = 1'b1;
        flags_o[FLG_PV] = par;
      end
      OP_OR, OP_XOR: flags_o[FLG_PV] = par;
      OP_SLL, OP_SLA, OP_ROL: begin
        flags_o[FLG_C]  = a_i[7];
        flags_o[FLG_PV] = par;
      end
      OP_SRL, OP_SRA, OP_ROR: begin
        flags_o[FLG_C]  = a_i[0];
        flags_o[FLG_PV] = par;
      end
      OP_INC: begin
        flags_o[FLG_C]  = c_i;
        flags_o[FLG_H]  = (a_i[3:0] == 4'hF);
        flags_o[FLG_PV] = (a_i == 8'h7F);
      end
      OP_DEC: begin
        flags_o[FLG_C]  = c_i;
        flags_o[FLG_H]  = (a_i[3:0] == 4'h0);
        flags_o[FLG_PV] = (a_i == 8'h80);
        flags_o[FLG_N]  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - request/response sequencer owning the accumulator and flags in front of the 8-bit ALU
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter logic [7:0] ACC_RST = 8'hFF,
  parameter logic [7:0] FLG_RST = 8'hFF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [4:0] req_op,
  input  logic [7:0] req_src,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic [7:0] resp_result,
  output logic [7:0] resp_flags,
  output logic       resp_err,
  output logic [7:0] acc,
  output logic [7:0] flags,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [4:0] alu_opcode,
  input  logic [7:0] alu_out,
  input  logic [7:0] alu_status
);

  state_e     state_q;
  logic [7:0] acc_q;
  logic [7:0] flags_q;
  logic [7:0] alu_a_q;
  logic [7:0] alu_b_q;
  logic [4:0] alu_opcode_q;
  logic [4:0] op_q;
  logic       err_q;
  logic       resp_valid_q;
  logic [7:0] resp_result_q;
  logic [7:0] resp_flags_q;
  logic       resp_err_q;

  logic [4:0] alu_opcode_d;
  logic [7:0] alu_b_d;
  logic [7:0] flags_d;
  logic       unused_status;

  assign unused_status = ^alu_status;

  alu_flag_gen u_flag_gen (
    .op_i    (op_q),
    .a_i     (alu_a_q),
    .b_i     (alu_b_q),
    .r_i     (alu_out),
    .c_i     (flags_q[FLG_C]),
    .flags_o (flags_d)
  );

  // CP runs as SUB; shifts are single-bit; INC/DEC ignore the source operand.
  always_comb begin
    alu_opcode_d = req_op;
    alu_b_d      = req_src;
    if (op_illegal(req_op)) begin
      alu_opcode_d = 5'd0;
    end else if (req_op == OP_CP) begin
      alu_opcode_d = OP_SUB;
    end
    if (req_op >= OP_SLL && req_op <= OP_ROR) begin
      alu_b_d = 8'h01;
    end else if (req_op == OP_INC || req_op == OP_DEC) begin
      alu_b_d = 8'h00;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      acc_q         <= ACC_RST;
      flags_q       <= FLG_RST;
      alu_a_q       <= 8'h00;
      alu_b_q       <= 8'h00;
      alu_opcode_q  <= 5'd0;
      op_q          <= 5'd0;
      err_q         <= 1'b0;
      resp_valid_q  <= 1'b0;
      resp_result_q <= 8'h00;
      resp_flags_q  <= 8'h00;
      resp_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            alu_a_q      <= acc_q;
            alu_b_q      <= alu_b_d;
            alu_opcode_q <= alu_opcode_d;
            op_q         <= req_op;
            err_q        <= op_illegal(req_op);
            state_q      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          resp_valid_q <= 1'b1;
          resp_err_q   <= err_q;
          state_q      <= ST_RESP;
          if (err_q) begin
            resp_result_q <= 8'h00;
            resp_flags_q  <= flags_q;
          end else begin
            resp_result_q <= alu_out;
            resp_flags_q  <= flags_d;
            flags_q       <= flags_d;
            if (op_q != OP_CP) begin
              acc_q <= alu_out;
            end
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            state_q      <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready   = (state_q == ST_IDLE);
  assign resp_valid  = resp_valid_q;
  assign resp_result = resp_result_q;
  assign resp_flags  = resp_flags_q;
  assign resp_err    = resp_err_q;
  assign acc         = acc_q;
  assign flags       = flags_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_opcode  = alu_opcode_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb/tb_alu_issue_ctrl.sv - directed self-checking bench for alu_issue_ctrl with a behavioural ALU
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [4:0] req_op;
  logic [7:0] req_src;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_result;
  logic [7:0] resp_flags;
  logic       resp_err;
  logic [7:0] acc;
  logic [7:0] flags;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [4:0] alu_opcode;
  logic [7:0] alu_out_m;
  logic [7:0] alu_status_m;

  int n_pass  = 0;
  int n_total = 0;
  int cyc     = 0;

  logic       rdy, rve, rvr, er;
  logic [7:0] bex, res, fl;
  logic [4:0] opx;
  int         acyc;

  alu_issue_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_src     (req_src),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_result (resp_result),
    .resp_flags  (resp_flags),
    .resp_err    (resp_err),
    .acc         (acc),
    .flags       (flags),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_opcode  (alu_opcode),
    .alu_out     (alu_out_m),
    .alu_status  (alu_status_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign alu_status_m = 8'h5A;

  always_comb begin
    case (alu_opcode)
      OP_ADD:         alu_out_m = alu_a + alu_b;
      OP_SUB:         alu_out_m = alu_a - alu_b;
      OP_AND:         alu_out_m = alu_a & alu_b;
      OP_OR:          alu_out_m = alu_a | alu_b;
      OP_XOR:         alu_out_m = alu_a ^ alu_b;
      OP_SLL, OP_SLA: alu_out_m = alu_a << alu_b[2:0];
      OP_SRL:         alu_out_m = alu_a >> alu_b[2:0];
      OP_SRA:         alu_out_m = {alu_a[7], alu_a[7:1]};
      OP_ROL:         alu_out_m = {alu_a[6:0], alu_a[7]};
      OP_ROR:         alu_out_m = {alu_a[0], alu_a[7:1]};
      OP_INC:         alu_out_m = alu_a + 8'd1;
      OP_DEC:         alu_out_m = alu_a - 8'd1;
      default:        alu_out_m = 8'h00;
    endcase
  end

  // Starts and ends on a falling edge with the controller idle (resp_ready assumed high).
  task automatic do_op(input logic [4:0] op, input logic [7:0] src,
                       output logic o_rdy, output logic o_rve, output logic [7:0] o_bex,
                       output logic [4:0] o_opx, output logic o_rvr, output logic [7:0] o_res,
                       output logic [7:0] o_fl, output logic o_er, output int o_cyc);
    req_valid = 1'b1;
    req_op    = op;
    req_src   = src;
    o_rdy     = req_ready;
    @(posedge clk);
    o_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    o_rve = resp_valid;
    o_bex = alu_b;
    o_opx = alu_opcode;
    @(negedge clk);
    o_rvr = resp_valid;
    o_res = resp_result;
    o_fl  = resp_flags;
    o_er  = resp_err;
    @(negedge clk);
  endtask

  task automatic load_acc(input logic [7:0] v);
    do_op(OP_AND, 8'h00, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    do_op(OP_OR, v, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_op = 5'd0; req_src = 8'h00; resp_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if (acc !== 8'hFF) $display("FAIL reset_acc: got %h want ff", acc); else n_pass++;
    n_total++; if (flags !== 8'hFF) $display("FAIL reset_flags: got %h want ff", flags); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL reset_req_ready: got %b want 1", req_ready); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL reset_resp_valid: got %b want 0", resp_valid); else n_pass++;
    n_total++; if ({alu_a, alu_b, alu_opcode} !== 21'd0) $display("FAIL reset_alu: got %h %h %h want 0", alu_a, alu_b, alu_opcode); else n_pass++;
    n_total++; if ({resp_result, resp_flags, resp_err} !== 17'd0) $display("FAIL reset_resp: got %h %h %b want 0", resp_result, resp_flags, resp_err); else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    load_acc(8'h7F);
    do_op(OP_ADD, 8'h01, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (rdy !== 1'b1) $display("FAIL add_req_ready: got %b want 1", rdy); else n_pass++;
    n_total++; if (rve !== 1'b0) $display("FAIL add_valid_exec: got %b want 0", rve); else n_pass++;
    n_total++; if (rvr !== 1'b1) $display("FAIL add_valid_resp: got %b want 1", rvr); else n_pass++;
    n_total++; if (res !== 8'h80) $display("FAIL add_result: got %h want 80", res); else n_pass++;
    n_total++; if (fl !== 8'h94) $display("FAIL add_flags: got %h want 94", fl); else n_pass++;
    n_total++; if (acc !== 8'h80) $display("FAIL add_acc: got %h want 80", acc); else n_pass++;
  endtask

  task automatic test_sub();
    load_acc(8'h00);
    do_op(OP_SUB, 8'h01, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (res !== 8'hFF) $display("FAIL sub_result: got %h want ff", res); else n_pass++;
    n_total++; if (fl !== 8'h93) $display("FAIL sub_flags: got %h want 93", fl); else n_pass++;
    n_total++; if (acc !== 8'hFF) $display("FAIL sub_acc: got %h want ff", acc); else n_pass++;
  endtask

  task automatic test_cp();
    load_acc(8'h42);
    do_op(OP_CP, 8'h42, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (opx !== OP_SUB) $display("FAIL cp_opcode: got %h want %h", opx, OP_SUB); else n_pass++;
    n_total++; if (res !== 8'h00) $display("FAIL cp_result: got %h want 00", res); else n_pass++;
    n_total++; if (fl !== 8'h42) $display("FAIL cp_flags: got %h want 42", fl); else n_pass++;
    n_total++; if (acc !== 8'h42) $display("FAIL cp_acc: got %h want 42", acc); else n_pass++;
  endtask

  task automatic test_shift();
    load_acc(8'h81);
    do_op(OP_SRL, 8'h33, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (bex !== 8'h01) $display("FAIL srl_alu_b: got %h want 01", bex); else n_pass++;
    n_total++; if (res !== 8'h40) $display("FAIL srl_result: got %h want 40", res); else n_pass++;
    n_total++; if (fl !== 8'h01) $display("FAIL srl_flags: got %h want 01", fl); else n_pass++;
  endtask

  task automatic test_and_inc_dec();
    load_acc(8'hF0);
    do_op(OP_AND, 8'h0F, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (res !== 8'h00) $display("FAIL and_result: got %h want 00", res); else n_pass++;
    n_total++; if (fl !== 8'h54) $display("FAIL and_flags: got %h want 54", fl); else n_pass++;
    load_acc(8'h00);
    do_op(OP_SUB, 8'h01, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    do_op(OP_INC, 8'h55, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (bex !== 8'h00) $display("FAIL inc_alu_b: got %h want 00", bex); else n_pass++;
    n_total++; if (acc !== 8'h00) $display("FAIL inc_acc: got %h want 00", acc); else n_pass++;
    n_total++; if (fl !== 8'h51) $display("FAIL inc_flags: got %h want 51", fl); else n_pass++;
    do_op(OP_DEC, 8'hAA, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (acc !== 8'hFF) $display("FAIL dec_acc: got %h want ff", acc); else n_pass++;
    n_total++; if (fl !== 8'h93) $display("FAIL dec_flags: got %h want 93", fl); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int prev;
    do_op(OP_XOR, 8'hFF, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (fl !== 8'h44) $display("FAIL b2b_xor_flags: got %h want 44", fl); else n_pass++;
    prev = acyc;
    do_op(OP_OR, 8'h3C, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (rdy !== 1'b1) $display("FAIL b2b_ready: got %b want 1", rdy); else n_pass++;
    n_total++; if (acyc - prev !== 3) $display("FAIL b2b_spacing: got %0d want 3", acyc - prev); else n_pass++;
    n_total++; if (fl !== 8'h04) $display("FAIL b2b_or_flags: got %h want 04", fl); else n_pass++;
    do_op(OP_ADD, 8'hC4, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (res !== 8'h00) $display("FAIL b2b_add_result: got %h want 00", res); else n_pass++;
    n_total++; if (fl !== 8'h51) $display("FAIL b2b_add_flags: got %h want 51", fl); else n_pass++;
  endtask

  task automatic test_stall();
    resp_ready = 1'b0;
    req_valid = 1'b1; req_op = OP_ADD; req_src = 8'h05;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      n_total++; if (resp_valid !== 1'b1) $display("FAIL stall_valid[%0d]: got %b want 1", i, resp_valid); else n_pass++;
      n_total++; if ({resp_result, resp_flags} !== 16'h0500) $display("FAIL stall_resp[%0d]: got %h %h want 05 00", i, resp_result, resp_flags); else n_pass++;
      n_total++; if (req_ready !== 1'b0) $display("FAIL stall_req_ready[%0d]: got %b want 0", i, req_ready); else n_pass++;
      @(negedge clk);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    n_total++; if (resp_valid !== 1'b0) $display("FAIL stall_release_valid: got %b want 0", resp_valid); else n_pass++;
    n_total++; if (req_ready !== 1'b1) $display("FAIL stall_release_ready: got %b want 1", req_ready); else n_pass++;
  endtask

  task automatic test_illegal();
    do_op(OP_SUB, 8'h06, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    do_op(OP_COMPARE, 8'h12, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (opx !== 5'd0) $display("FAIL ill05_opcode: got %h want 00", opx); else n_pass++;
    n_total++; if (er !== 1'b1) $display("FAIL ill05_err: got %b want 1", er); else n_pass++;
    n_total++; if (res !== 8'h00) $display("FAIL ill05_result: got %h want 00", res); else n_pass++;
    n_total++; if (fl !== 8'h93) $display("FAIL ill05_flags: got %h want 93", fl); else n_pass++;
    n_total++; if ({acc, flags} !== 16'hFF93) $display("FAIL ill05_state: got %h %h want ff 93", acc, flags); else n_pass++;
    do_op(5'h1F, 8'h34, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if ({er, acc, flags} !== 17'h1FF93) $display("FAIL ill1f: got %b %h %h want 1 ff 93", er, acc, flags); else n_pass++;
    do_op(OP_INC, 8'h00, rdy, rve, bex, opx, rvr, res, fl, er, acyc);
    n_total++; if (er !== 1'b0) $display("FAIL legal_err_clear: got %b want 0", er); else n_pass++;
  endtask

  task automatic test_reset_mid();
    load_acc(8'h12);
    req_valid = 1'b1; req_op = OP_ADD; req_src = 8'h01;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_total++; if ({acc, flags} !== 16'hFFFF) $display("FAIL midrst_state: got %h %h want ff ff", acc, flags); else n_pass++;
    n_total++; if ({alu_a, alu_b, alu_opcode} !== 21'd0) $display("FAIL midrst_alu: got %h %h %h want 0", alu_a, alu_b, alu_opcode); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", resp_valid); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_total++; if ({resp_valid, req_ready, acc} !== 10'h1FF) $display("FAIL midrst_after: got %b %b %h want 0 1 ff", resp_valid, req_ready, acc); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_cp();
    test_shift();
    test_and_inc_dec();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
